// File: rtl/keypad_debounce_unit.sv
// Per-key synchronizer, tick-gated debouncer and press/hold/repeat FSM for the 12-key keypad.
// All key buses share one bit map; every key runs an independent copy of the same logic.
`timescale 1ns/1ps
module keypad_debounce_unit #(
   parameter int NUM_KEYS     = 12,
   parameter int DEB_TICKS    = 4,
   parameter int HOLD_TICKS   = 50,
   parameter int REPEAT_TICKS = 10,
   parameter int CNT_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_hold,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                any_press
);

   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEB_TICKS);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_TICKS);

   logic [NUM_KEYS-1:0] rise_all;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic             sync_p0, sync_p1;
      logic             level, level_nxt;
      logic             press_q, rel_q, repeat_q, repeat_nxt;
      logic             rise, fall;
      logic [CNT_W-1:0] dcnt, dcnt_nxt, hcnt, hcnt_nxt;
      state_t           state, state_nxt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            level    <= 1'b0;
            dcnt     <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            repeat_q <= 1'b0;
            hcnt     <= '0;
            state    <= IDLE;
         end else begin
            sync_p0  <= key_raw[k];
            sync_p1  <= sync_p0;
            level    <= level_nxt;
            dcnt     <= dcnt_nxt;
            press_q  <= rise;
            rel_q    <= fall;
            repeat_q <= repeat_nxt;
            hcnt     <= hcnt_nxt;
            state    <= state_nxt;
         end
      end

      // Debounce: the level flips only after DEB_TICKS consecutive disagreeing ticks.
      always_comb begin
         level_nxt = level;
         dcnt_nxt  = dcnt;
         rise      = 1'b0;
         fall      = 1'b0;
         if (tick) begin
            if (sync_p1 != level) begin
               if (dcnt + ONE == DEB_LIM) begin
                  level_nxt = sync_p1;
                  dcnt_nxt  = '0;
                  rise      = sync_p1;
                  fall      = !sync_p1;
               end else begin
                  dcnt_nxt = dcnt + ONE;
               end
            end else begin
               dcnt_nxt = '0;
            end
         end
      end

      // Release is checked first so it overrides a coincident hold or repeat event.
      always_comb begin
         state_nxt  = state;
         hcnt_nxt   = hcnt;
         repeat_nxt = 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state_nxt = PRESSED;
                  hcnt_nxt  = '0;
               end
            end
            PRESSED: begin
               if (fall) begin
                  state_nxt = IDLE;
                  hcnt_nxt  = '0;
               end else if (tick) begin
                  if (hcnt + ONE == HOLD_LIM) begin
                     state_nxt  = HELD;
                     repeat_nxt = 1'b1;
                     hcnt_nxt   = '0;
                  end else begin
                     hcnt_nxt = hcnt + ONE;
                  end
               end
            end
            HELD: begin
               if (fall) begin
                  state_nxt = IDLE;
                  hcnt_nxt  = '0;
               end else if (tick && (REPEAT_TICKS != 0)) begin
                  if (hcnt + ONE == REP_LIM) begin
                     repeat_nxt = 1'b1;
                     hcnt_nxt   = '0;
                  end else begin
                     hcnt_nxt = hcnt + ONE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               hcnt_nxt  = '0;
            end
         endcase
      end

      assign key_level[k]   = level;
      assign key_press[k]   = press_q;
      assign key_release[k] = rel_q;
      assign key_repeat[k]  = repeat_q;
      assign key_hold[k]    = (state == HELD);
      assign rise_all[k]    = rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_press <= 1'b0;
      end else begin
         any_press <= |rise_all;
      end
   end

endmodule

// File: tb/tb_keypad_debounce_unit.sv
// Scenario bench for keypad_debounce_unit: tasks queue expected pulses (kind, keys, tick index)
// and a negedge monitor pops and compares them as the DUT emits press/release/repeat pulses.
`timescale 1ns/1ps
module tb_keypad_debounce_unit;
   localparam int NK       = 12;
   localparam int DEB      = 4;
   localparam int HOLD     = 50;
   localparam int REP      = 10;
   localparam int TICK_DIV = 4;
   localparam int LAT      = DEB + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tick;
   logic [NK-1:0] key_raw;
   logic [NK-1:0] key_level, key_press, key_release, key_hold, key_repeat;
   logic          any_press;

   typedef struct {
      int          kind;
      logic [NK-1:0] bits;
      int          tk;
   } ev_t;

   ev_t           exp_q[$];
   ev_t           ev;
   logic [NK-1:0] obs [3];
   int            checks   = 0;
   int            errors   = 0;
   int            tick_num = 0;
   int            any_cnt  = 0;
   bit            mon_en   = 1'b0;

   keypad_debounce_unit #(
      .NUM_KEYS(NK), .DEB_TICKS(DEB), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .key_raw(key_raw),
      .key_level(key_level), .key_press(key_press), .key_release(key_release),
      .key_hold(key_hold), .key_repeat(key_repeat), .any_press(any_press)
   );

   always #5 clk = ~clk;

   // Scoreboard: kind 0 = press, 1 = release, 2 = repeat
   always @(negedge clk) begin
      if (mon_en) begin
         obs[0] = key_press;
         obs[1] = key_release;
         obs[2] = key_repeat;
         if (any_press === 1'b1) any_cnt++;
         for (int k = 0; k < 3; k++) begin
            if (obs[k] !== '0) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_pulse kind=%0d got=%h at tick %0d, required no pulse", k, obs[k], tick_num);
               end else begin
                  ev = exp_q.pop_front();
                  if (ev.kind != k || ev.bits !== obs[k] || ev.tk != tick_num) begin
                     errors++;
                     $display("FAIL pulse got kind=%0d bits=%h tick=%0d, required kind=%0d bits=%h tick=%0d",
                              k, obs[k], tick_num, ev.kind, ev.bits, ev.tk);
                  end
               end
            end
         end
         if (key_press !== '0 || any_press !== 1'b0) begin
            checks++;
            if (any_press !== (|key_press)) begin
               errors++;
               $display("FAIL any_press got=%b, required=%b (key_press=%h)", any_press, |key_press, key_press);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick_start();
      tick = 1'b1;
      tick_num++;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic tick_rest();
      repeat (TICK_DIV - 1) @(negedge clk);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_start();
         tick_rest();
      end
   endtask

   task automatic push_ev(input int kind, input logic [NK-1:0] bits, input int tk);
      ev_t e;
      e.kind = kind;
      e.bits = bits;
      e.tk   = tk;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      int tn;
      rst_n   = 1'b0;
      tick    = 1'b0;
      key_raw = '1;
      repeat (3) @(negedge clk);
      do_ticks(2);
      checks++;
      if ({key_level, key_press, key_release, key_hold, key_repeat, any_press} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got level=%h press=%h rel=%h hold=%h rep=%h any=%b, required all 0",
                  key_level, key_press, key_release, key_hold, key_repeat, any_press);
      end
      mon_en = 1'b1;
      tn = tick_num;
      push_ev(0, 12'hFFF, tn + LAT);
      rst_n = 1'b1;
      do_ticks(LAT + 3);
      checks++;
      if (key_level !== 12'hFFF) begin
         errors++;
         $display("FAIL reset_level got=%h required=fff", key_level);
      end
      tn = tick_num;
      push_ev(1, 12'hFFF, tn + LAT);
      key_raw = '0;
      do_ticks(LAT + 3);
      checks++;
      if (key_level !== '0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_release got level=%h pending=%0d, required level=000 pending=0", key_level, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bounce();
      int tn;
      for (int i = 0; i < 6; i++) begin
         key_raw[10] = ~key_raw[10];
         do_ticks(1);
      end
      checks++;
      if (key_level[10] !== 1'b0) begin
         errors++;
         $display("FAIL bounce_level_during got=%b required=0", key_level[10]);
      end
      tn = tick_num;
      push_ev(0, 12'h400, tn + LAT);
      key_raw[10] = 1'b1;
      do_ticks(LAT + 5);
      checks++;
      if (key_level[10] !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bounce_press got level=%b pending=%0d, required level=1 pending=0", key_level[10], exp_q.size());
         exp_q.delete();
      end
      tn = tick_num;
      push_ev(1, 12'h400, tn + LAT);
      key_raw[10] = 1'b0;
      do_ticks(LAT + 3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL bounce_release pending got=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_glitch();
      key_raw[3] = 1'b1;
      do_ticks(DEB - 1);
      key_raw[3] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick_start();
         checks++;
         if (key_level[3] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_level got=%b required=0 at tick %0d", key_level[3], tick_num);
         end
         tick_rest();
      end
   endtask

   task automatic test_hold_repeat();
      int  t0;
      int  t_rel;
      logic exp_h;
      t0    = tick_num + LAT;
      t_rel = t0 + 75 + LAT;
      push_ev(0, 12'h200, t0);
      push_ev(2, 12'h200, t0 + HOLD);
      push_ev(2, 12'h200, t0 + HOLD + REP);
      push_ev(2, 12'h200, t0 + HOLD + 2 * REP);
      push_ev(1, 12'h200, t_rel);
      key_raw[9] = 1'b1;
      while (tick_num < t0 + 75) begin
         tick_start();
         exp_h = (tick_num >= t0 + HOLD);
         checks++;
         if (key_hold[9] !== exp_h) begin
            errors++;
            $display("FAIL hold_flag got=%b required=%b at tick %0d", key_hold[9], exp_h, tick_num);
         end
         tick_rest();
      end
      key_raw[9] = 1'b0;
      for (int i = 0; i < LAT + 3; i++) begin
         tick_start();
         if (tick_num == t_rel) begin
            checks++;
            if ({key_hold[9], key_release[9]} !== 2'b01) begin
               errors++;
               $display("FAIL hold_release got hold=%b release=%b, required hold=0 release=1",
                        key_hold[9], key_release[9]);
            end
         end
         tick_rest();
      end
      checks++;
      if (key_hold[9] !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL hold_end got hold=%b pending=%0d, required hold=0 pending=0", key_hold[9], exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_simultaneous();
      int tn;
      any_cnt = 0;
      tn = tick_num;
      push_ev(0, 12'h801, tn + LAT);
      key_raw[0]  = 1'b1;
      key_raw[11] = 1'b1;
      do_ticks(LAT + 3);
      checks++;
      if (any_cnt != 1 || key_level !== 12'h801) begin
         errors++;
         $display("FAIL simul_press got any_cycles=%0d level=%h, required any_cycles=1 level=801", any_cnt, key_level);
      end
      tn = tick_num;
      push_ev(1, 12'h801, tn + LAT);
      key_raw = '0;
      do_ticks(LAT + 3);
      checks++;
      if (any_cnt != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL simul_release got any_cycles=%0d pending=%0d, required any_cycles=1 pending=0",
                  any_cnt, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_async_reset();
      int t0;
      int tn;
      t0 = tick_num + LAT;
      push_ev(0, 12'h020, t0);
      push_ev(2, 12'h020, t0 + HOLD);
      key_raw[5] = 1'b1;
      while (tick_num < t0 + HOLD + 5) do_ticks(1);
      checks++;
      if (key_hold[5] !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre_hold got=%b required=1", key_hold[5]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({key_level, key_press, key_release, key_hold, key_repeat, any_press} !== '0) begin
         errors++;
         $display("FAIL areset_clear got level=%h hold=%h rel=%h, required all 0", key_level, key_hold, key_release);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tn = tick_num;
      push_ev(0, 12'h020, tn + LAT);
      do_ticks(LAT + 3);
      checks++;
      if (key_level[5] !== 1'b1 || key_hold[5] !== 1'b0) begin
         errors++;
         $display("FAIL areset_repress got level=%b hold=%b, required level=1 hold=0", key_level[5], key_hold[5]);
      end
      tn = tick_num;
      push_ev(1, 12'h020, tn + LAT);
      key_raw[5] = 1'b0;
      do_ticks(LAT + 3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL areset_pending got=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      tick    = 1'b0;
      key_raw = '0;
      @(negedge clk);
      test_reset();
      test_bounce();
      test_glitch();
      test_hold_repeat();
      test_simultaneous();
      test_async_reset();
      do_ticks(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
